// File: rtl/execute_issue_stage_pkg.sv
// execute_issue_stage_pkg: shared core types for the execute stage and its ALU interface
package execute_issue_stage_pkg;
   localparam int XLEN = 32;
   localparam int REG_ADDR_W = 5;
   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
      ALU_OR, ALU_AND, ALU_COMPARE_EQUAL, ALU_COMPARE_NOT_EQUAL,
      ALU_COMPARE_LT, ALU_COMPARE_GE, ALU_COMPARE_LTU, ALU_COMPARE_GEU
   } alu_op_t;
   typedef enum logic [1:0] {OP1_RS1, OP1_PC, OP1_ZERO} op1_sel_t;
   typedef enum logic {OP2_RS2, OP2_IMM} op2_sel_t;
   typedef enum logic [1:0] {EXEC_ALU, EXEC_BRANCH, EXEC_JAL, EXEC_JALR} exec_kind_t;
   typedef struct packed {
      logic [XLEN-1:0] result;
      logic [REG_ADDR_W-1:0] rd;
      logic write_en;
   } exec_out_t;
   function automatic logic writes_rd(exec_kind_t kind, logic [REG_ADDR_W-1:0] rd);
      return (rd != '0) && (kind != EXEC_BRANCH);
   endfunction
endpackage

// File: rtl/execute_issue_stage_branch_resolver.sv
// branch_resolver: decides control-flow change, its target and the link value
module branch_resolver
   import execute_issue_stage_pkg::*;
(
   input  exec_kind_t      kind,
   input  logic [XLEN-1:0] pc,
   input  logic [XLEN-1:0] imm,
   input  logic [XLEN-1:0] alu_result,
   input  logic            alu_result_nonzero,
   output logic            taken,
   output logic [XLEN-1:0] target,
   output logic [XLEN-1:0] link
);
   // branches compare in the ALU, so their target needs a private adder
   always_comb begin
      taken  = (kind == EXEC_BRANCH) ? alu_result_nonzero : (kind == EXEC_JAL || kind == EXEC_JALR);
      target = (kind == EXEC_BRANCH) ? pc + imm :
               (kind == EXEC_JALR)   ? {alu_result[XLEN-1:1], 1'b0} : alu_result;
      link   = pc + 32'd4;
   end
endmodule

// File: rtl/execute_issue_stage.sv
// execute_issue_stage: drives the ALU, resolves control flow, registers EX/MEM (optional EXECUTE_BYPASS_EN)
module execute_issue_stage
   import execute_issue_stage_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  alu_op_t               in_alu_op,
   input  op1_sel_t              in_op1_sel,
   input  op2_sel_t              in_op2_sel,
   input  exec_kind_t            in_kind,
   input  logic [XLEN-1:0]       in_rs1_val,
   input  logic [XLEN-1:0]       in_rs2_val,
   input  logic [XLEN-1:0]       in_imm,
   input  logic [XLEN-1:0]       in_pc,
   input  logic [REG_ADDR_W-1:0] in_rd,
`ifdef EXECUTE_BYPASS_EN
   input  logic [REG_ADDR_W-1:0] in_rs1_idx,
   input  logic [REG_ADDR_W-1:0] in_rs2_idx,
`endif
   output alu_op_t               alu_operation,
   output logic [XLEN-1:0]       alu_operand_1,
   output logic [XLEN-1:0]       alu_operand_2,
   input  logic [XLEN-1:0]       alu_result,
   input  logic                  alu_result_nonzero,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [XLEN-1:0]       out_result,
   output logic [REG_ADDR_W-1:0] out_rd,
   output logic                  out_write_en,
   output logic                  redirect_valid,
   output logic [XLEN-1:0]       redirect_pc,
   input  logic                  flush
);
   localparam logic STATE_RUN    = 1'b0;
   localparam logic STATE_SQUASH = 1'b1;

   logic            state;
   logic            accept;
   logic            take;
   logic            taken;
   logic [XLEN-1:0] target;
   logic [XLEN-1:0] link;
   logic [XLEN-1:0] rs1;
   logic [XLEN-1:0] rs2;
   exec_out_t       out_q;
   exec_out_t       next_out;

`ifdef EXECUTE_BYPASS_EN
   assign rs1 = (out_valid && out_write_en && in_rs1_idx != '0 && out_rd == in_rs1_idx) ? out_result : in_rs1_val;
   assign rs2 = (out_valid && out_write_en && in_rs2_idx != '0 && out_rd == in_rs2_idx) ? out_result : in_rs2_val;
`else
   assign rs1 = in_rs1_val;
   assign rs2 = in_rs2_val;
`endif

   branch_resolver u_branch_resolver (
      .kind               (in_kind),
      .pc                 (in_pc),
      .imm                (in_imm),
      .alu_result         (alu_result),
      .alu_result_nonzero (alu_result_nonzero),
      .taken              (taken),
      .target             (target),
      .link               (link)
   );

   // ALU drive is forced to a benign add of zeros when no instruction is present
   always_comb begin
      alu_operation = in_valid ? in_alu_op : ALU_ADD;
      alu_operand_1 = !in_valid ? '0 : (in_op1_sel == OP1_RS1) ? rs1 : (in_op1_sel == OP1_PC) ? in_pc : '0;
      alu_operand_2 = !in_valid ? '0 : (in_op2_sel == OP2_IMM) ? in_imm : rs2;
      in_ready      = (state == STATE_SQUASH || !out_valid || out_ready) && !flush;
      accept        = in_valid && in_ready;
      take          = accept && (state == STATE_RUN);
      next_out      = '{result: (in_kind == EXEC_JAL || in_kind == EXEC_JALR) ? link : alu_result,
                        rd: in_rd, write_en: writes_rd(in_kind, in_rd)};
   end

   // EX/MEM register, one-cycle redirect and squash FSM; flush outranks everything but reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= STATE_RUN;
         out_valid      <= 1'b0;
         out_q          <= '0;
         redirect_valid <= 1'b0;
         redirect_pc    <= '0;
      end else if (flush) begin
         state          <= STATE_RUN;
         out_valid      <= 1'b0;
         redirect_valid <= 1'b0;
      end else begin
         state          <= (take && taken) ? STATE_SQUASH : STATE_RUN;
         redirect_valid <= take && taken;
         if (take && taken) redirect_pc <= target;
         if (take) begin
            out_valid <= 1'b1;
            out_q     <= next_out;
         end else if (out_ready) out_valid <= 1'b0;
      end
   end

   assign out_result   = out_q.result;
   assign out_rd       = out_q.rd;
   assign out_write_en = out_q.write_en;
endmodule

// File: tb/tb_execute_issue_stage.sv
// tb_execute_issue_stage: directed self-checking bench with a small behavioural ALU
module tb_execute_issue_stage;
   import execute_issue_stage_pkg::*;

   logic            clk = 1'b0;
   logic            reset;
   logic            in_valid;
   logic            in_ready;
   alu_op_t         in_alu_op;
   op1_sel_t        in_op1_sel;
   op2_sel_t        in_op2_sel;
   exec_kind_t      in_kind;
   logic [31:0]     in_rs1_val, in_rs2_val, in_imm, in_pc;
   logic [4:0]      in_rd;
`ifdef EXECUTE_BYPASS_EN
   logic [4:0]      in_rs1_idx, in_rs2_idx;
`endif
   alu_op_t         alu_operation;
   logic [31:0]     alu_operand_1, alu_operand_2, alu_result;
   logic            alu_result_nonzero;
   logic            out_valid, out_ready, out_write_en;
   logic [31:0]     out_result;
   logic [4:0]      out_rd;
   logic            redirect_valid;
   logic [31:0]     redirect_pc;
   logic            flush;
   int              checks = 0;
   int              errors = 0;

   always #5 clk = ~clk;

   execute_issue_stage dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_alu_op(in_alu_op), .in_op1_sel(in_op1_sel), .in_op2_sel(in_op2_sel), .in_kind(in_kind),
      .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val), .in_imm(in_imm), .in_pc(in_pc), .in_rd(in_rd),
`ifdef EXECUTE_BYPASS_EN
      .in_rs1_idx(in_rs1_idx), .in_rs2_idx(in_rs2_idx),
`endif
      .alu_operation(alu_operation), .alu_operand_1(alu_operand_1), .alu_operand_2(alu_operand_2),
      .alu_result(alu_result), .alu_result_nonzero(alu_result_nonzero),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_rd(out_rd),
      .out_write_en(out_write_en), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush(flush)
   );

   // behavioural ALU standing in for the external one
   always_comb begin
      alu_result = (alu_operation == ALU_ADD) ? alu_operand_1 + alu_operand_2 :
                   (alu_operation == ALU_SUB) ? alu_operand_1 - alu_operand_2 :
                   (alu_operation == ALU_COMPARE_EQUAL) ? {31'd0, alu_operand_1 == alu_operand_2} : 32'd0;
      alu_result_nonzero = |alu_result;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input alu_op_t op, input op1_sel_t s1, input op2_sel_t s2, input exec_kind_t k,
                        input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm,
                        input logic [31:0] pc, input logic [4:0] rd);
      in_valid = 1'b1; in_alu_op = op; in_op1_sel = s1; in_op2_sel = s2; in_kind = k;
      in_rs1_val = rs1; in_rs2_val = rs2; in_imm = imm; in_pc = pc; in_rd = rd;
      #1;
   endtask

   initial begin
      reset = 1'b1; flush = 1'b0; out_ready = 1'b1; in_valid = 1'b0;
      in_alu_op = ALU_SUB; in_op1_sel = OP1_RS1; in_op2_sel = OP2_IMM; in_kind = EXEC_ALU;
      in_rs1_val = 32'd5; in_rs2_val = 32'd6; in_imm = 32'd7; in_pc = 32'h10; in_rd = 5'd1;
`ifdef EXECUTE_BYPASS_EN
      in_rs1_idx = 5'd0; in_rs2_idx = 5'd0;
`endif
      step(); step();
      reset = 1'b0;
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_redirect_valid", redirect_valid, 0);
      check("rst_out_result", out_result, 0);
      check("rst_out_rd", out_rd, 0);
      check("rst_redirect_pc", redirect_pc, 0);
      check("rst_in_ready", in_ready, 1);
      check("idle_alu_op", alu_operation, ALU_ADD);
      check("idle_operand_1", alu_operand_1, 0);
      check("idle_operand_2", alu_operand_2, 0);

      drive(ALU_ADD, OP1_RS1, OP2_IMM, EXEC_ALU, 32'd5, 32'd0, 32'd7, 32'h0, 5'd3);
      check("alu_operand_1", alu_operand_1, 5);
      check("alu_operand_2", alu_operand_2, 7);
      step();
      in_valid = 1'b0;
      check("alu_out_valid", out_valid, 1);
      check("alu_out_result", out_result, 12);
      check("alu_out_rd", out_rd, 3);
      check("alu_write_en", out_write_en, 1);
      check("alu_no_redirect", redirect_valid, 0);
      step();
      check("alu_drained", out_valid, 0);

      drive(ALU_COMPARE_EQUAL, OP1_RS1, OP2_RS2, EXEC_BRANCH, 32'd9, 32'd9, 32'h20, 32'h100, 5'd2);
      step();
      check("br_redirect_valid", redirect_valid, 1);
      check("br_redirect_pc", redirect_pc, 32'h120);
      check("br_write_en", out_write_en, 0);
      drive(ALU_ADD, OP1_RS1, OP2_IMM, EXEC_ALU, 32'd1, 32'd0, 32'd1, 32'h124, 5'd5);
      check("squash_in_ready", in_ready, 1);
      step();
      in_valid = 1'b0;
      check("squash_redirect_once", redirect_valid, 0);
      check("squash_dropped", out_valid, 0);

      drive(ALU_COMPARE_EQUAL, OP1_RS1, OP2_RS2, EXEC_BRANCH, 32'd9, 32'd8, 32'h20, 32'h100, 5'd0);
      step();
      check("nt_no_redirect", redirect_valid, 0);
      check("nt_out_valid", out_valid, 1);
      drive(ALU_ADD, OP1_RS1, OP2_IMM, EXEC_ALU, 32'd2, 32'd0, 32'd3, 32'h104, 5'd6);
      check("nt_in_ready", in_ready, 1);
      step();
      in_valid = 1'b0;
      check("nt_next_valid", out_valid, 1);
      check("nt_next_result", out_result, 5);
      check("nt_next_rd", out_rd, 6);

      drive(ALU_ADD, OP1_RS1, OP2_IMM, EXEC_JALR, 32'h203, 32'd0, 32'd4, 32'h40, 5'd1);
      step();
      in_valid = 1'b0;
      check("jalr_redirect_valid", redirect_valid, 1);
      check("jalr_redirect_pc", redirect_pc, 32'h206);
      check("jalr_link", out_result, 32'h44);
      check("jalr_write_en", out_write_en, 1);
      step();
      check("jalr_redirect_once", redirect_valid, 0);

      drive(ALU_ADD, OP1_PC, OP2_IMM, EXEC_JAL, 32'd0, 32'd0, 32'd8, 32'hFFFF_FFFC, 5'd1);
      check("jal_operand_1_pc", alu_operand_1, 32'hFFFF_FFFC);
      step();
      in_valid = 1'b0;
      check("jal_redirect_pc_wrap", redirect_pc, 32'h4);
      check("jal_link_wrap", out_result, 32'h0);
      step();

      out_ready = 1'b0;
      drive(ALU_ADD, OP1_RS1, OP2_IMM, EXEC_ALU, 32'd10, 32'd0, 32'd20, 32'h200, 5'd7);
      check("bp_first_ready", in_ready, 1);
      step();
      drive(ALU_ADD, OP1_RS1, OP2_IMM, EXEC_ALU, 32'd1, 32'd0, 32'd1, 32'h204, 5'd8);
      for (int i = 0; i < 3; i++) begin
         check("bp_in_ready", in_ready, 0);
         check("bp_hold_result", out_result, 30);
         check("bp_hold_rd", out_rd, 7);
         check("bp_hold_valid", out_valid, 1);
         step();
      end
      out_ready = 1'b1;
      #1;
      check("bp_release_ready", in_ready, 1);
      step();
      in_valid = 1'b0;
      check("bp_b2b_valid", out_valid, 1);
      check("bp_b2b_result", out_result, 2);
      check("bp_b2b_rd", out_rd, 8);

      drive(ALU_COMPARE_EQUAL, OP1_RS1, OP2_RS2, EXEC_BRANCH, 32'd9, 32'd9, 32'h20, 32'h100, 5'd0);
      flush = 1'b1;
      #1;
      check("flush_in_ready", in_ready, 0);
      step();
      flush = 1'b0; in_valid = 1'b0;
      check("flush_no_redirect", redirect_valid, 0);
      check("flush_out_valid", out_valid, 0);
      drive(ALU_ADD, OP1_RS1, OP2_IMM, EXEC_ALU, 32'd5, 32'd0, 32'd7, 32'h300, 5'd4);
      step();
      check("flush_run_valid", out_valid, 1);
      check("flush_run_result", out_result, 12);
`ifdef EXECUTE_BYPASS_EN
      drive(ALU_ADD, OP1_RS1, OP2_IMM, EXEC_ALU, 32'd0, 32'd0, 32'd1, 32'h304, 5'd9);
      in_rs1_idx = 5'd4;
      #1;
      check("bypass_operand_1", alu_operand_1, 12);
      in_rs1_idx = 5'd0;
`endif
      in_valid = 1'b0;
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("mid_reset_valid", out_valid, 0);
      check("mid_reset_result", out_result, 0);
      check("mid_reset_rd", out_rd, 0);
      check("mid_reset_redirect", redirect_valid, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
